// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modexp requester: controller state
// encoding, default bus width and the encrypt/decrypt mode values.
package rsa_pkg;

  localparam int BUS_WIDTH_DEF = 256;

  // Controller states; the top keeps its state register as plain logic.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } rsa_state_e;

  // Value of in_decrypt selecting each exponent.
  localparam logic ENC = 1'b0;
  localparam logic DEC = 1'b1;

endpackage

// File: rtl/rsa_key_store.sv
// Key register file for the RSA requester: holds modulus n and exponents
// e/d, tracks whether a key set has been loaded, and picks the exponent
// for the current request.
module rsa_key_store
  import rsa_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_en,
  input  logic [BUS_WIDTH-1:0] key_n,
  input  logic [BUS_WIDTH-1:0] key_e,
  input  logic [BUS_WIDTH-1:0] key_d,
  input  logic                 decrypt,
  output logic [BUS_WIDTH-1:0] n,
  output logic [BUS_WIDTH-1:0] exp_sel,
  output logic                 key_valid
);

  logic [BUS_WIDTH-1:0] e_q;
  logic [BUS_WIDTH-1:0] d_q;

  // Capture a new key set when the controller allows it; reset forgets keys.
  always_ff @(posedge clk) begin
    if (!reset) begin
      n         <= '0;
      e_q       <= '0;
      d_q       <= '0;
      key_valid <= 1'b0;
    end else if (load_en) begin
      n         <= key_n;
      e_q       <= key_e;
      d_q       <= key_d;
      key_valid <= 1'b1;
    end
  end

  // Exponent for the request being presented this cycle.
  always_comb begin
    exp_sel = (decrypt == DEC) ? d_q : e_q;
  end

endmodule

// File: rtl/rsa_modexp_requester.sv
// Initiator-side controller for the square_and_multiply modexp engine.
// Accepts one request at a time, runs it through the engine and holds the
// result until the consumer takes it.
// Optional macro RSA_MSG_RANGE_CHECK_EN: requests with in_data >= n bypass
// the engine and return an error marker (out_err=1, out_data=0).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; a source holds valid and its data stable until that edge,
// and valid never depends on ready.
module rsa_modexp_requester
  import rsa_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_load,
  input  logic [BUS_WIDTH-1:0] key_n,
  input  logic [BUS_WIDTH-1:0] key_e,
  input  logic [BUS_WIDTH-1:0] key_d,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_decrypt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic                 out_err,
  output logic [BUS_WIDTH-1:0] me_m,
  output logic [BUS_WIDTH-1:0] me_e,
  output logic [BUS_WIDTH-1:0] me_n,
  output logic                 me_ready,
  input  logic [BUS_WIDTH-1:0] me_out,
  input  logic                 me_valid,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_RESP  = RESP;

  logic [1:0]           state;
  logic                 accept;
  logic                 key_valid;
  logic                 load_en;
  logic [BUS_WIDTH-1:0] n_q;
  logic [BUS_WIDTH-1:0] exp_sel;

  // Handshake qualifiers; a key load racing an accepted request loses.
  always_comb begin
    in_ready  = key_valid && (state == ST_IDLE);
    accept    = in_valid && in_ready;
    load_en   = key_load && (state == ST_IDLE) && !accept;
    dbg_state = state;
  end

  rsa_key_store #(
    .BUS_WIDTH(BUS_WIDTH)
  ) u_key_store (
    .clk      (clk),
    .reset    (reset),
    .load_en  (load_en),
    .key_n    (key_n),
    .key_e    (key_e),
    .key_d    (key_d),
    .decrypt  (in_decrypt),
    .n        (n_q),
    .exp_sel  (exp_sel),
    .key_valid(key_valid)
  );

`ifdef RSA_MSG_RANGE_CHECK_EN
  logic err_q;
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  // Request sequencing: IDLE -> ISSUE -> DRAIN -> RESP -> IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      me_m      <= '0;
      me_e      <= '0;
      me_n      <= '0;
      me_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef RSA_MSG_RANGE_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
`ifdef RSA_MSG_RANGE_CHECK_EN
            if (in_data >= n_q) begin
              out_data  <= '0;
              err_q     <= 1'b1;
              out_valid <= 1'b1;
              state     <= ST_RESP;
            end else
`endif
            begin
              me_m     <= in_data;
              me_e     <= exp_sel;
              me_n     <= n_q;
              me_ready <= 1'b1;
              state    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (me_valid) begin
            out_data <= me_out;
            me_ready <= 1'b0;
`ifdef RSA_MSG_RANGE_CHECK_EN
            err_q    <= 1'b0;
`endif
            state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Engine must be back to idle before the result is offered.
          if (!me_valid) begin
            out_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef RSA_MSG_RANGE_CHECK_EN
            err_q     <= 1'b0;
`endif
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_requester.sv
// Self-checking bench for rsa_modexp_requester with a behavioural engine
// and a modexp reference model over small RSA keys.
module tb_rsa_modexp_requester;

  localparam int W = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         key_load;
  logic [W-1:0] key_n, key_e, key_d;
  logic         in_valid, in_ready, in_decrypt;
  logic [W-1:0] in_data;
  logic         out_valid, out_ready, out_err;
  logic [W-1:0] out_data;
  logic [W-1:0] me_m, me_e, me_n, me_out;
  logic         me_ready, me_valid;
  logic [1:0]   dbg_state;

  rsa_modexp_requester #(.BUS_WIDTH(W)) dut (
    .clk(clk), .reset(rst_n), .key_load(key_load),
    .key_n(key_n), .key_e(key_e), .key_d(key_d),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_decrypt(in_decrypt), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .me_m(me_m), .me_e(me_e),
    .me_n(me_n), .me_ready(me_ready), .me_out(me_out), .me_valid(me_valid),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_mis = 0;
  logic [W-1:0] exp_q[$];
  logic         err_q[$];
  logic [W-1:0] last_data;
  logic         last_err;
  longint unsigned m_n, m_e, m_d;
  int rst_cnt = 0;
  int eng_starts = 0;
  int eng_lat_min = 0;
  int rdy_mode = 0;

  longint unsigned tbl_n[4] = '{3233, 497, 143, 187};
  longint unsigned tbl_e[4] = '{17, 13, 7, 3};
  longint unsigned tbl_d[4] = '{2753, 97, 103, 107};

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned modexp(input longint unsigned b,
                                             input longint unsigned e,
                                             input longint unsigned n);
    longint unsigned r, x, k;
    r = 1 % n;
    x = b % n;
    k = e;
    while (k != 0) begin
      if (k[0]) r = (r * x) % n;
      x = (x * x) % n;
      k = k >> 1;
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input longint unsigned n, input longint unsigned e,
                          input longint unsigned d);
    key_load = 1'b1;
    key_n = W'(n);
    key_e = W'(e);
    key_d = W'(d);
    tick();
    key_load = 1'b0;
    check("load_in_ready", W'(in_ready), 1);
    m_n = n;
    m_e = e;
    m_d = d;
  endtask

  task automatic send_req(input longint unsigned msg, input logic dec, input logic junk);
    bit acc = 0;
    in_valid = 1'b1;
    in_data = W'(msg);
    in_decrypt = dec;
    if (junk) begin
      key_load = 1'b1;
      key_n = W'($urandom_range(5000, 9000));
      key_e = W'($urandom_range(1, 99));
      key_d = W'($urandom_range(1, 99));
    end
    for (int c = 0; c < 500 && !acc; c++) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      tick();
    end
    in_valid = 1'b0;
    key_load = 1'b0;
    if (!acc) begin
      check("accept_timeout", 0, 1);
    end else begin
`ifdef RSA_MSG_RANGE_CHECK_EN
      if (msg >= m_n) begin
        exp_q.push_back('0);
        err_q.push_back(1'b1);
      end else
`endif
      begin
        exp_q.push_back(W'(modexp(msg, dec ? m_d : m_e, m_n)));
        err_q.push_back(1'b0);
      end
    end
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      tick();
      cyc++;
    end
    if (exp_q.size() != 0) check("drain_timeout", W'(exp_q.size()), 0);
  endtask

  // ---------------- consumer ready pattern ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", W'(out_valid), 0);
      end else begin
        logic [W-1:0] ed;
        logic ee;
        ed = exp_q.pop_front();
        ee = err_q.pop_front();
        check("out_data", out_data, ed);
        check("out_err", W'(out_err), W'(ee));
        last_data = out_data;
        last_err = out_err;
      end
    end
  end

  // ---------------- behavioural engine ----------------
  initial begin
    me_valid = 1'b0;
    me_out = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && me_ready) begin
        int rc;
        logic [W-1:0] m0, e0, n0;
        longint unsigned res;
        rc = rst_cnt;
        m0 = me_m;
        e0 = me_e;
        n0 = me_n;
        eng_starts++;
        res = (n0[63:0] == 0) ? 0 : modexp(m0[63:0], e0[63:0], n0[63:0]);
        repeat ($urandom_range(eng_lat_min, eng_lat_min + 4)) begin
          @(posedge clk);
          #1;
        end
        if (rc == rst_cnt) begin
          check("eng_ready_held", W'(me_ready), 1);
          check("eng_m_held", me_m, m0);
        end
        me_out = W'(res);
        me_valid = 1'b1;
        @(posedge clk);
        #1;
        check("eng_ready_drop", W'(me_ready), 0);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        me_valid = 1'b0;
      end
    end
  end

  // ---------------- global time limit ----------------
  initial begin
    #500000;
    n_mis++;
    $display("FAIL global_timeout: got running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int s0;
    rst_n = 1'b0;
    key_load = 1'b0;
    key_n = '0;
    key_e = '0;
    key_d = '0;
    in_valid = 1'b0;
    in_data = '0;
    in_decrypt = 1'b0;
    repeat (3) tick();

    check("rst_in_ready", W'(in_ready), 0);
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_out_err", W'(out_err), 0);
    check("rst_out_data", out_data, 0);
    check("rst_me_ready", W'(me_ready), 0);
    check("rst_me_m", me_m, 0);
    check("rst_me_e", me_e, 0);
    check("rst_me_n", me_n, 0);
    check("rst_state", W'(dbg_state), 0);
    rst_n = 1'b1;
    tick();

    // Requests before any key must be refused.
    in_valid = 1'b1;
    in_data = W'(5);
    repeat (5) begin
      tick();
      check("nokey_in_ready", W'(in_ready), 0);
      check("nokey_me_ready", W'(me_ready), 0);
    end
    in_valid = 1'b0;
    check("preload_in_ready", W'(in_ready), 0);
    load_key(3233, 17, 2753);

    // Textbook key: encrypt then decrypt.
    send_req(65, 1'b0, 1'b0);
    wait_drain();
    check("enc65", last_data, 2790);
    send_req(2790, 1'b1, 1'b0);
    wait_drain();
    check("dec2790", last_data, 65);

    // Consumer back-pressure holds the result.
    load_key(497, 13, 97);
    rdy_mode = 2;
    tick();
    send_req(4, 1'b0, 1'b0);
    for (int c = 0; c < 200 && !out_valid; c++) tick();
    repeat (50) begin
      tick();
      check("bp_out_valid", W'(out_valid), 1);
      check("bp_out_data", out_data, 445);
      check("bp_in_ready", W'(in_ready), 0);
    end
    @(negedge clk);
    rdy_mode = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("bp_in_ready_after", W'(in_ready), 1);
    check("bp_out_valid_after", W'(out_valid), 0);
    check("bp_result", last_data, 445);

    // Reset while the engine is busy.
    load_key(3233, 17, 2753);
    eng_lat_min = 12;
    send_req(65, 1'b0, 1'b0);
    tick();
    tick();
    check("issue_me_ready", W'(me_ready), 1);
    check("issue_state", W'(dbg_state), 1);
    @(negedge clk);
    rst_n = 1'b0;
    rst_cnt++;
    tick();
    check("midrst_me_ready", W'(me_ready), 0);
    check("midrst_out_valid", W'(out_valid), 0);
    check("midrst_in_ready", W'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    err_q.delete();
    repeat (30) tick();
    check("midrst_no_out", W'(out_valid), 0);
    check("midrst_keys_gone", W'(in_ready), 0);
    eng_lat_min = 0;
    load_key(3233, 17, 2753);
    send_req(65, 1'b0, 1'b0);
    wait_drain();
    check("reload_enc65", last_data, 2790);

    // Message equal to the modulus.
    s0 = eng_starts;
    send_req(3233, 1'b0, 1'b0);
    wait_drain();
    check("range_data", last_data, 0);
`ifdef RSA_MSG_RANGE_CHECK_EN
    check("range_err", W'(last_err), 1);
    check("range_starts", W'(eng_starts - s0), 0);
`else
    check("range_err", W'(last_err), 0);
    check("range_starts", W'(eng_starts - s0), 1);
`endif

    // Randomized traffic with key changes, junk loads and back-pressure.
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      longint unsigned msg;
      if (i % 8 == 0) begin
        int k;
        k = $urandom_range(0, 3);
        wait_drain();
        load_key(tbl_n[k], tbl_e[k], tbl_d[k]);
      end
      if (i % 10 == 5) msg = m_n + $urandom_range(0, 2);
      else msg = $urandom_range(0, int'(m_n) - 1);
      send_req(msg, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    wait_drain();
    rdy_mode = 0;
    repeat (5) tick();
    check("end_queue_empty", W'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
